// File: rtl/line_raster_engine.sv
// line_raster_engine: Bresenham line rasteriser emitting one pixel per valid/ready beat.
// Optional LINE_SKIP_LAST_EN omits the endpoint (polyline mode).
module line_raster_engine #(
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] x0,
  input  logic [CW-1:0] y0,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] y1,
  output logic          busy,
  output logic          done,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_last
);
  typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
  localparam logic [CW-1:0] ONE = CW'(1);
  state_t state, state_n;
  logic [CW-1:0] x, y, xe, ye, nx, ny;
  logic signed [CW+1:0] dx, dy, err, e2, err_n, dx_s, dy_s;
  logic sx, sy, step_x, step_y, at_end, next_end, last, empty, beat;
  always_comb begin
    dx_s = {2'b00, x < xe ? xe - x : x - xe};
    dy_s = -{2'b00, y < ye ? ye - y : y - ye};
    e2 = err <<< 1;
    step_x = e2 >= dy;
    step_y = e2 <= dx;
    nx = step_x ? (sx ? x + ONE : x - ONE) : x;
    ny = step_y ? (sy ? y + ONE : y - ONE) : y;
    err_n = err + (step_x ? dy : '0) + (step_y ? dx : '0);
    at_end = x == xe && y == ye;
    next_end = nx == xe && ny == ye;
`ifdef LINE_SKIP_LAST_EN
    last = next_end;
    empty = at_end;
`else
    last = at_end;
    empty = 1'b0;
`endif
    beat = state == DRAW && pix_ready;
    state_n = state == IDLE  ? (start ? SETUP : IDLE) :
              state == SETUP ? (empty ? DONE : DRAW) :
              state == DRAW  ? (beat && last ? DONE : DRAW) : IDLE;
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0;
      y <= '0;
      xe <= '0;
      ye <= '0;
      dx <= '0;
      dy <= '0;
      err <= '0;
      sx <= 1'b0;
      sy <= 1'b0;
    end else if (state == IDLE && start) begin
      x <= x0;
      y <= y0;
      xe <= x1;
      ye <= y1;
    end else if (state == SETUP) begin
      dx <= dx_s;
      dy <= dy_s;
      err <= dx_s + dy_s;
      sx <= x < xe;
      sy <= y < ye;
    end else if (beat && !last) begin
      x <= nx;
      y <= ny;
      err <= err_n;
    end
  end
  assign busy = state != IDLE;
  assign done = state == DONE;
  assign pix_valid = state == DRAW;
  assign pix_last = state == DRAW && last;
  assign pix_x = x;
  assign pix_y = y;
endmodule

// File: tb/tb_line_raster_engine.sv
// tb_line_raster_engine: directed checks of beats, backpressure, ignored start and reset abort.
module tb_line_raster_engine;
  localparam int CW = 10;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, pix_ready = 1'b1;
  logic [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0;
  logic busy, done, pix_valid, pix_last;
  logic [CW-1:0] pix_x, pix_y;
  int checks = 0, errors = 0;
  int qx[$], qy[$];
  line_raster_engine #(.CW(CW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .busy(busy), .done(done), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic run_seg(input int ax, input int ay, input int bx, input int by,
                         input int stall_at, input int stall_n, input int start_at);
    int n, idx, st, cyc;
    idx = 0;
    st = 0;
    cyc = 0;
`ifdef LINE_SKIP_LAST_EN
    void'(qx.pop_back());
    void'(qy.pop_back());
`endif
    n = qx.size();
    @(negedge clk);
    x0 = CW'(ax);
    y0 = CW'(ay);
    x1 = CW'(bx);
    y1 = CW'(by);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("setup_busy", busy, 1);
    chk("setup_valid", pix_valid, 0);
    @(negedge clk);
    while (idx < n && cyc < 100) begin
      pix_ready = !(idx == stall_at && st < stall_n);
      start = idx == start_at;
      chk("valid", pix_valid, 1);
      chk("pix_x", pix_x, qx[idx]);
      chk("pix_y", pix_y, qy[idx]);
      chk("pix_last", pix_last, idx == n - 1);
      if (pix_ready) idx++;
      else st++;
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    pix_ready = 1'b1;
    chk("beat_count", idx, n);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_valid", pix_valid, 0);
    @(negedge clk);
    chk("after_done", done, 0);
    chk("after_busy", busy, 0);
    @(negedge clk);
    chk("stay_idle", busy, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_last", pix_last, 0);
    chk("rst_x", pix_x, 0);
    chk("rst_y", pix_y, 0);
    rst = 1'b0;
    qx = '{0, 1, 2, 3};
    qy = '{0, 1, 2, 3};
    run_seg(0, 0, 3, 3, -1, 0, -1);
    qx = '{5, 4, 3, 2, 1, 0};
    qy = '{2, 2, 1, 1, 0, 0};
    run_seg(5, 2, 0, 0, -1, 0, -1);
    qx = '{7, 7, 7, 7, 7};
    qy = '{0, 1, 2, 3, 4};
    run_seg(7, 0, 7, 4, 1, 3, -1);
    qx = '{9};
    qy = '{9};
    run_seg(9, 9, 9, 9, -1, 0, -1);
    qx = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    qy = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_seg(0, 0, 10, 0, -1, 0, 3);
    @(negedge clk);
    x0 = 0;
    y0 = 0;
    x1 = 20;
    y1 = 5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_valid", pix_valid, 0);
    chk("abort_last", pix_last, 0);
    chk("abort_x", pix_x, 0);
    chk("abort_y", pix_y, 0);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_abort", done, 0);
    end
    qx = '{2, 3, 3, 4, 4};
    qy = '{5, 4, 3, 2, 1};
    run_seg(2, 5, 4, 1, -1, 0, -1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
